// File: rtl/saph_pix_extract.sv
// Splits 32-bit packed words into 1..32 bpp pixels, right-aligned, one per pixel handshake.
// Latency: start -> word_ready next cycle; word accept -> pix_valid next cycle; 1 pixel/cycle sustained.
// Backpressure: pix_ready low holds shreg/idx/remaining; words are pulled only when the span needs them.
module saph_pix_extract #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       bpp_log,
  input  logic [4:0]       skip,
  input  logic [LEN_W-1:0] count,
  output logic             busy,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic [31:0]      word_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [31:0]      pix_data,
  output logic             pix_last
);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t           state;
  logic [31:0]      shreg;
  logic [4:0]       idx;
  logic [LEN_W-1:0] remaining;
  logic             first;
  logic [2:0]       bpp_r;
  logic [4:0]       skip_r;

  logic [4:0]  last_idx;
  logic [31:0] mask;
  logic [31:0] sh_amt;
  logic        end_of_word;
  logic        last_pix;
  logic        pix_xfer;
  logic        word_xfer;

  // ppw-1 doubles as the skip modulo mask and the end-of-word index
  assign last_idx    = 5'd31 >> bpp_r;
  assign mask        = (bpp_r == 3'd5) ? 32'hFFFF_FFFF : ((32'd1 << (32'd1 << bpp_r)) - 32'd1);
  assign sh_amt      = {27'd0, idx} << bpp_r;
  assign end_of_word = (idx == last_idx);
  assign last_pix    = (remaining == LEN_W'(1));

  assign busy       = (state != IDLE);
  assign pix_valid  = (state == EMIT);
  assign pix_data   = pix_valid ? ((shreg >> sh_amt) & mask) : 32'd0;
  assign pix_last   = pix_valid & last_pix;
  assign word_ready = (state == LOAD) |
                      ((state == EMIT) & pix_ready & end_of_word & (remaining > LEN_W'(1)));
  assign pix_xfer   = pix_valid & pix_ready;
  assign word_xfer  = word_valid & word_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      remaining <= '0;
      first     <= 1'b0;
      bpp_r     <= '0;
      skip_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (count != '0) && (bpp_log <= 3'd5)) begin
            bpp_r     <= bpp_log;
            skip_r    <= skip;
            remaining <= count;
            first     <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (word_xfer) begin
            shreg <= word_data;
            idx   <= first ? (skip_r & last_idx) : 5'd0;
            first <= 1'b0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (pix_xfer) begin
            remaining <= remaining - LEN_W'(1);
            if (last_pix) begin
              state <= IDLE;
            end else if (end_of_word) begin
              // fused reload keeps the stream gapless when upstream is ready
              if (word_xfer) begin
                shreg <= word_data;
                idx   <= 5'd0;
              end else begin
                state <= LOAD;
              end
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saph_pix_extract.sv
// Directed bench for saph_pix_extract: queued word source, pixel scoreboard, handshake checks.
module tb_saph_pix_extract;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  bpp_log;
  logic [4:0]  skip;
  logic [15:0] count;
  logic        busy;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] pix_data;
  logic        pix_last;

  saph_pix_extract #(.LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bpp_log(bpp_log), .skip(skip),
    .count(count), .busy(busy), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          npix = 0;
  int          wacc = 0;
  int          wacc0 = 0;
  int          exp_w = 0;
  bit          wtaken = 1'b0;
  logic [32:0] sbq[$];
  logic [31:0] wq[$];
  int          xc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and handshake monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (word_valid && word_ready) begin
        wacc++;
        wtaken = 1'b1;
      end
      if (pix_valid && pix_ready) begin
        npix++;
        xc.push_back(cyc);
        if (sbq.size() == 0) chk("unexpected_pixel", {31'd0, pix_last, pix_data}, 64'h1_FFFF_FFFF_FFFF);
        else chk("pixel", {31'd0, pix_last, pix_data}, {31'd0, sbq.pop_front()});
      end else if (!pix_valid) begin
        chk("idle_pix_zero", {31'd0, pix_last, pix_data}, 64'd0);
      end
    end
  end

  // Word source: presents the head of wq, pops after each accepted transfer
  initial begin
    logic [31:0] tmp;
    word_valid = 1'b0;
    word_data  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (wtaken) begin
        if (wq.size() > 0) tmp = wq.pop_front();
        wtaken = 1'b0;
      end
      word_valid = (wq.size() > 0);
      word_data  = word_valid ? wq[0] : 32'd0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input int bl, input int sk, input int cnt);
    @(posedge clk);
    #1;
    start = 1'b1; bpp_log = 3'(bl); skip = 5'(sk); count = 16'(cnt);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic flush_words();
    @(posedge clk);
    #2;
    wq.delete();
    wtaken = 1'b0;
  endtask

  // Reference built from a linear pixel index over the word stream
  task automatic model_span(input int bl, input int sk, input int cnt);
    int bpp, ppw, p;
    logic [31:0] words[$];
    logic [31:0] w, v, m;
    bpp = 1 << bl;
    ppw = 32 >> bl;
    p = sk % ppw;
    exp_w = (p + cnt + ppw - 1) / ppw;
    for (int i = 0; i < exp_w; i++) begin
      w = $urandom;
      words.push_back(w);
      wq.push_back(w);
    end
    m = (bpp == 32) ? 32'hFFFF_FFFF : 32'((64'd1 << bpp) - 64'd1);
    for (int i = 0; i < cnt; i++) begin
      w = words[p / ppw];
      v = (w >> ((p % ppw) * bpp)) & m;
      sbq.push_back({(i == cnt - 1), v});
      p++;
    end
    wacc0 = wacc;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({tag, "_done"}, {63'd0, busy}, 64'd0);
    chk({tag, "_sb_empty"}, 64'(sbq.size()), 64'd0);
    chk({tag, "_words"}, 64'(wacc - wacc0), 64'(exp_w));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bpp_log = 3'd0; skip = 5'd0; count = 16'd0; pix_ready = 1'b1;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_word_ready", {63'd0, word_ready}, 64'd0);
    chk("rst_pix", {30'd0, pix_valid, pix_last, pix_data}, 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // 8 bpp basic, with a spare word that must stay unconsumed
    wq.push_back(32'hDDCC_BBAA);
    wq.push_back(32'h1111_1111);
    sbq.push_back({1'b0, 32'hAA}); sbq.push_back({1'b0, 32'hBB});
    sbq.push_back({1'b0, 32'hCC}); sbq.push_back({1'b1, 32'hDD});
    exp_w = 1; wacc0 = wacc;
    do_start(3, 0, 4);
    @(negedge clk);
    chk("lat_word_ready", {63'd0, word_ready}, 64'd1);
    chk("lat_pix_not_yet", {63'd0, pix_valid}, 64'd0);
    @(negedge clk);
    chk("lat_pix_valid", {63'd0, pix_valid}, 64'd1);
    wait_done("basic8");
    chk("basic8_spare_left", 64'(wq.size()), 64'd1);
    flush_words();

    // 4 bpp, skip into first word, span ends mid second word; start pulsed mid-span
    wq.push_back(32'h7654_3210);
    wq.push_back(32'hFEDC_BA98);
    for (int i = 3; i <= 9; i++) sbq.push_back({(i == 9), 32'(i)});
    exp_w = 2; wacc0 = wacc;
    do_start(2, 3, 7);
    repeat (2) @(negedge clk);
    do_start(0, 0, 1);
    wait_done("skip4");

    // 32 bpp gapless through fused reloads, skip irrelevant
    xc.delete();
    model_span(5, 9, 3);
    do_start(5, 9, 3);
    wait_done("thru32");
    chk("thru32_xfers", 64'(xc.size()), 64'd3);
    if (xc.size() == 3) chk("thru32_gapless", 64'(xc[2] - xc[0]), 64'd2);

    // 1 bpp with a 5-cycle stall on the second pixel
    wq.push_back(32'h0000_0005);
    sbq.push_back({1'b0, 32'd1}); sbq.push_back({1'b0, 32'd0}); sbq.push_back({1'b1, 32'd1});
    exp_w = 1; wacc0 = wacc;
    do_start(0, 0, 3);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pix_valid) break;
    end
    chk("stall_first_valid", {63'd0, pix_valid}, 64'd1);
    @(posedge clk);
    #1;
    pix_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", {30'd0, pix_valid, pix_last, pix_data}, {30'd0, 1'b1, 1'b0, 32'd0});
      chk("stall_no_word", {63'd0, word_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    pix_ready = 1'b1;
    wait_done("stall1");

    // Ignored starts: zero count and invalid bpp
    wq.push_back(32'hCAFE_F00D);
    wacc0 = wacc;
    do_start(3, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ign_cnt0", {62'd0, busy, word_ready}, 64'd0);
    end
    do_start(6, 0, 5);
    repeat (3) begin
      @(negedge clk);
      chk("ign_bpp6", {62'd0, busy, word_ready}, 64'd0);
    end
    chk("ign_no_words", 64'(wacc - wacc0), 64'd0);
    flush_words();

    // 2 bpp with random downstream stalls
    model_span(1, 13, 20);
    do_start(1, 13, 20);
    for (int k = 0; k < 200 && busy; k++) begin
      @(posedge clk);
      #1;
      pix_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk);
    #1;
    pix_ready = 1'b1;
    wait_done("rand2");

    // Reset mid-span after three pixels, then a single-pixel span
    model_span(4, 0, 10);
    npix = 0;
    do_start(4, 0, 10);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (npix >= 3) break;
    end
    chk("mid_rst_progress", 64'(npix), 64'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_outs", {29'd0, word_ready, pix_valid, pix_last, pix_data}, 64'd0);
    sbq.delete();
    wq.delete();
    wtaken = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_hold", {62'd0, busy, word_ready}, 64'd0);
    #2;
    rst_n = 1'b1;
    model_span(3, 0, 1);
    do_start(3, 0, 1);
    wait_done("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
